// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between P_REQ_NUM byte-stream requesters.
// Round-robin grant at packet granularity, with forced rotation after a byte burst or an idle
// gap. Accepted bytes land in a one-entry output register on the transmitter's valid/ready port.
module uart_tx_arbiter #(
  parameter int unsigned P_REQ_NUM         = 4,
  parameter int unsigned P_UART_DATA_WIDTH = 8,
  parameter int unsigned P_BURST_MAX       = 16,
  parameter int unsigned P_GAP_MAX         = 255
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic [P_REQ_NUM*P_UART_DATA_WIDTH-1:0] i_req_data,
  input  logic [P_REQ_NUM-1:0]                   i_req_valid,
  input  logic [P_REQ_NUM-1:0]                   i_req_last,
  output logic [P_REQ_NUM-1:0]                   o_req_ready,
  output logic [P_UART_DATA_WIDTH-1:0]           o_user_tx_data,
  output logic                                   o_user_tx_valid,
  input  logic                                   i_user_tx_ready,
  output logic [P_REQ_NUM-1:0]                   o_grant,
  output logic                                   o_busy
);

  localparam int unsigned IdxW = (P_REQ_NUM > 1) ? $clog2(P_REQ_NUM) : 1;
  localparam int unsigned CntW = $clog2(P_BURST_MAX + 1);
  localparam int unsigned GapW = $clog2(P_GAP_MAX + 1);

  localparam logic [CntW-1:0] BurstLast = CntW'(P_BURST_MAX - 1);
  localparam logic [GapW-1:0] GapLast   = GapW'(P_GAP_MAX - 1);
  // Pointer starts at the highest index so requester 0 is scanned first after reset.
  localparam logic [IdxW-1:0] PtrReset  = IdxW'(P_REQ_NUM - 1);

  typedef enum logic [0:0] {StArb, StSend} state_e;

  state_e                         state_q;
  logic [P_REQ_NUM-1:0]           grant_q;
  logic [IdxW-1:0]                ptr_q;      // current owner while sending, last owner otherwise
  logic [CntW-1:0]                byte_cnt_q;
  logic [GapW-1:0]                gap_cnt_q;
  logic [P_UART_DATA_WIDTH-1:0]   tx_data_q;
  logic                           tx_valid_q;

  logic                           own_valid;
  logic                           own_last;
  logic [P_UART_DATA_WIDTH-1:0]   own_data;
  logic                           slot_free;
  logic                           req_hs;
  logic                           drain;
  logic                           arb_found;
  logic [IdxW-1:0]                arb_idx;
  logic [IdxW-1:0]                cand_idx;
  logic [P_REQ_NUM-1:0]           arb_onehot;

  // Select the current owner's request lines.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int unsigned k = 0; k < P_REQ_NUM; k++) begin
      if (ptr_q == IdxW'(k)) begin
        own_valid = i_req_valid[k];
        own_last  = i_req_last[k];
        own_data  = i_req_data[k*P_UART_DATA_WIDTH +: P_UART_DATA_WIDTH];
      end
    end
  end

  // Round-robin scan starting just after the last owner, wrapping.
  always_comb begin
    arb_found  = 1'b0;
    arb_idx    = ptr_q;
    cand_idx   = ptr_q;
    arb_onehot = '0;
    for (int unsigned i = 1; i <= P_REQ_NUM; i++) begin
      cand_idx = IdxW'((32'(ptr_q) + i) % P_REQ_NUM);
      if (!arb_found && i_req_valid[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
    arb_onehot[arb_idx] = 1'b1;
  end

  // The output register can take a byte when empty or when it drains this same cycle.
  assign slot_free       = !tx_valid_q || i_user_tx_ready;
  assign req_hs          = (state_q == StSend) && own_valid && slot_free;
  assign drain           = tx_valid_q && i_user_tx_ready;

  assign o_req_ready     = (state_q == StSend && slot_free) ? grant_q : '0;
  assign o_grant         = grant_q;
  assign o_user_tx_data  = tx_data_q;
  assign o_user_tx_valid = tx_valid_q;
  assign o_busy          = (state_q == StSend) || tx_valid_q;

  // Arbitration FSM, burst/gap counters and the one-entry output register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StArb;
      grant_q    <= '0;
      ptr_q      <= PtrReset;
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      // A pending byte survives grant changes; a load wins over a drain.
      if (req_hs) begin
        tx_data_q  <= own_data;
        tx_valid_q <= 1'b1;
      end else if (drain) begin
        tx_valid_q <= 1'b0;
      end

      unique case (state_q)
        StArb: begin
          if (arb_found) begin
            state_q    <= StSend;
            grant_q    <= arb_onehot;
            ptr_q      <= arb_idx;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
          end else begin
            grant_q <= '0;
          end
        end
        StSend: begin
          if (req_hs) begin
            byte_cnt_q <= byte_cnt_q + CntW'(1);
            gap_cnt_q  <= '0;
            // End of packet or burst limit: rotate even in the middle of a packet.
            if (own_last || byte_cnt_q == BurstLast) begin
              state_q    <= StArb;
              grant_q    <= '0;
              byte_cnt_q <= '0;
            end
          end else if (!own_valid) begin
            if (gap_cnt_q == GapLast) begin
              state_q    <= StArb;
              grant_q    <= '0;
              byte_cnt_q <= '0;
              gap_cnt_q  <= '0;
            end else begin
              gap_cnt_q <= gap_cnt_q + GapW'(1);
            end
          end else begin
            // Valid but stalled by the output register: not an idle cycle.
            gap_cnt_q <= '0;
          end
        end
        default: state_q <= StArb;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios followed by randomized traffic, checked every
// cycle against a behavioural model of the arbiter plus an output byte-order scoreboard.
module tb_uart_tx_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned W     = 8;
  localparam int unsigned BURST = 4;
  localparam int unsigned GAP   = 8;

  logic           i_clk;
  logic           i_rst;
  logic [N*W-1:0] i_req_data;
  logic [N-1:0]   i_req_valid;
  logic [N-1:0]   i_req_last;
  logic [N-1:0]   o_req_ready;
  logic [W-1:0]   o_user_tx_data;
  logic           o_user_tx_valid;
  logic           i_user_tx_ready;
  logic [N-1:0]   o_grant;
  logic           o_busy;

  uart_tx_arbiter #(
    .P_REQ_NUM        (N),
    .P_UART_DATA_WIDTH(W),
    .P_BURST_MAX      (BURST),
    .P_GAP_MAX        (GAP)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_req_data     (i_req_data),
    .i_req_valid    (i_req_valid),
    .i_req_last     (i_req_last),
    .o_req_ready    (o_req_ready),
    .o_user_tx_data (o_user_tx_data),
    .o_user_tx_valid(o_user_tx_valid),
    .i_user_tx_ready(i_user_tx_ready),
    .o_grant        (o_grant),
    .o_busy         (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef logic [8:0] ent_t;  // {last, data}

  ent_t       src[N][$];      // bytes each requester still has to send
  logic [7:0] q_sent[$];      // bytes accepted, awaiting transmitter handshake

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: who owns the transmitter and what sits in the output slot.
  bit         m_send;
  int         m_owner;
  int         m_ptr;
  int         m_bytes;
  int         m_gap;
  bit         m_out_v;
  logic [7:0] m_out_d;

  int         stint;
  int         max_stint;
  logic [3:0] stint_g;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] d, input bit last);
    src[k].push_back({last, d});
  endtask

  task automatic gen_packet(input int k);
    int len;
    len = $urandom_range(1, 9);
    for (int b = 0; b < len; b++) push(k, 8'($urandom), b == len - 1);
  endtask

  task automatic model_reset();
    m_send  = 1'b0;
    m_owner = 0;
    m_ptr   = N - 1;
    m_bytes = 0;
    m_gap   = 0;
    m_out_v = 1'b0;
    m_out_d = 8'h00;
    q_sent.delete();
  endtask

  task automatic do_reset();
    i_rst           = 1'b1;
    i_req_valid     = '0;
    i_req_data      = '0;
    i_req_last      = '0;
    i_user_tx_ready = 1'b0;
    @(posedge i_clk);
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  // One clock cycle: drive at the falling edge, check, advance the model, pass the rising edge.
  task automatic step(input logic [3:0] vmask, input bit txr);
    logic [3:0]   v;
    logic [3:0]   l;
    logic [N*W-1:0] d;
    logic [3:0]   exp_g;
    logic [3:0]   exp_r;
    logic [3:0]   acc;
    logic [7:0]   exp_b;
    ent_t         e;
    bit           drain;
    bit           found;
    int           c;
    v = '0;
    l = '0;
    d = '0;
    for (int k = 0; k < N; k++) begin
      if (vmask[k] && src[k].size() > 0) begin
        v[k]       = 1'b1;
        d[k*W +: W] = src[k][0][7:0];
        l[k]       = src[k][0][8];
      end
    end
    i_req_valid     = v;
    i_req_data      = d;
    i_req_last      = l;
    i_user_tx_ready = txr;
    #1;
    exp_g = m_send ? (4'b0001 << m_owner) : 4'b0000;
    exp_r = (m_send && (!m_out_v || txr)) ? exp_g : 4'b0000;
    chk("grant", 32'(o_grant), 32'(exp_g));
    chk("req_ready", 32'(o_req_ready), 32'(exp_r));
    chk("tx_valid", 32'(o_user_tx_valid), 32'(m_out_v));
    chk("tx_data", 32'(o_user_tx_data), 32'(m_out_d));
    chk("busy", 32'(o_busy), 32'(m_send || m_out_v));
    if (o_user_tx_valid && txr) begin
      if (q_sent.size() == 0) begin
        chk("sb_underflow", 32'(q_sent.size()), 32'd1);
      end else begin
        exp_b = q_sent.pop_front();
        chk("sb_order", 32'(o_user_tx_data), 32'(exp_b));
      end
    end
    if (o_grant != stint_g) begin
      stint_g = o_grant;
      stint   = 0;
    end
    if (o_grant[2] && o_req_ready[2] && v[2]) begin
      stint++;
      if (stint > max_stint) max_stint = stint;
    end

    acc   = exp_r & v;
    drain = m_out_v && txr;
    if (!m_send) begin
      if (drain) m_out_v = 1'b0;
      found = 1'b0;
      for (int i = 1; i <= N; i++) begin
        c = (m_ptr + i) % N;
        if (!found && v[c]) begin
          found   = 1'b1;
          m_send  = 1'b1;
          m_owner = c;
          m_bytes = 0;
          m_gap   = 0;
        end
      end
    end else if (acc != 4'b0000) begin
      e = src[m_owner].pop_front();
      q_sent.push_back(e[7:0]);
      m_out_d = e[7:0];
      m_out_v = 1'b1;
      m_bytes++;
      m_gap = 0;
      if (e[8] || m_bytes == BURST) begin
        m_send = 1'b0;
        m_ptr  = m_owner;
      end
    end else begin
      if (drain) m_out_v = 1'b0;
      if (!v[m_owner]) begin
        m_gap++;
        if (m_gap == GAP) begin
          m_send = 1'b0;
          m_ptr  = m_owner;
        end
      end else begin
        m_gap = 0;
      end
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] gseq[$];
    int         left;
    stint     = 0;
    max_stint = 0;
    stint_g   = '0;
    model_reset();
    do_reset();

    // Reset state.
    chk("rst_grant", 32'(o_grant), 32'd0);
    chk("rst_tx_valid", 32'(o_user_tx_valid), 32'd0);
    chk("rst_tx_data", 32'(o_user_tx_data), 32'd0);

    // Requester 0 sends a three-byte packet; bytes leave on consecutive cycles.
    push(0, 8'h11, 1'b0);
    push(0, 8'h22, 1'b0);
    push(0, 8'h33, 1'b1);
    step(4'b0001, 1'b1);
    chk("t1_grant", 32'(o_grant), 32'h1);
    step(4'b0001, 1'b1);
    chk("t1_first_valid", 32'(o_user_tx_valid), 32'd1);
    chk("t1_first_data", 32'(o_user_tx_data), 32'h11);
    step(4'b0001, 1'b1);
    step(4'b0001, 1'b1);
    chk("t1_released", 32'(o_grant), 32'd0);
    chk("t1_last_data", 32'(o_user_tx_data), 32'h33);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    // Requesters 1 and 3 with single-byte packets must alternate.
    for (int p = 0; p < 4; p++) begin
      push(1, 8'(8'h40 + p), 1'b1);
      push(3, 8'(8'h80 + p), 1'b1);
    end
    for (int s = 0; s < 16; s++) begin
      step(4'b1010, 1'b1);
      if (o_grant != 4'b0000) gseq.push_back(o_grant);
    end
    chk("t2_count", 32'(gseq.size()), 32'd8);
    if (gseq.size() > 0) chk("t2_first", 32'(gseq[0]), 32'h2);
    for (int i = 1; i < gseq.size(); i++) chk("t2_alt", 32'(gseq[i] == gseq[i-1]), 32'd0);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    // Burst limit: requester 2 streams ten bytes while requester 0 waits.
    max_stint = 0;
    for (int b = 0; b < 10; b++) push(2, 8'(8'hC0 + b), b == 9);
    push(0, 8'h01, 1'b0);
    push(0, 8'h02, 1'b1);
    step(4'b0100, 1'b1);
    chk("t3_grant2", 32'(o_grant), 32'h4);
    for (int s = 0; s < 4; s++) step(4'b0101, 1'b1);
    chk("t3_rotate", 32'(o_grant), 32'd0);
    step(4'b0101, 1'b1);
    chk("t3_grant0", 32'(o_grant), 32'h1);
    for (int s = 0; s < 30; s++) step(4'b0101, 1'b1);
    chk("t3_max_burst", 32'(max_stint), 32'd4);
    chk("t3_req2_done", 32'(src[2].size()), 32'd0);
    chk("t3_req0_done", 32'(src[0].size()), 32'd0);

    // Transmitter stalls for 20 cycles with 0xA5 pending.
    push(0, 8'hA5, 1'b0);
    push(0, 8'h5A, 1'b1);
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);
    for (int s = 0; s < 20; s++) begin
      step(4'b0001, 1'b0);
      chk("t4_hold_data", 32'(o_user_tx_data), 32'hA5);
      chk("t4_hold_valid", 32'(o_user_tx_valid), 32'd1);
      chk("t4_no_ready", 32'(o_req_ready), 32'd0);
    end
    step(4'b0001, 1'b1);
    chk("t4_reload_data", 32'(o_user_tx_data), 32'h5A);
    chk("t4_reload_valid", 32'(o_user_tx_valid), 32'd1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    // Idle gap: requester 1 stops mid-packet, grant is released after GAP cycles.
    push(1, 8'h77, 1'b0);
    push(1, 8'h78, 1'b1);
    push(2, 8'h99, 1'b1);
    step(4'b0010, 1'b1);
    step(4'b0010, 1'b1);
    for (int s = 0; s < GAP - 1; s++) step(4'b0100, 1'b1);
    chk("t5_still_held", 32'(o_grant), 32'h2);
    step(4'b0100, 1'b1);
    chk("t5_released", 32'(o_grant), 32'd0);
    step(4'b0100, 1'b1);
    chk("t5_next_owner", 32'(o_grant), 32'h4);
    step(4'b0100, 1'b1);
    step(4'b0000, 1'b1);

    // Reset in the middle of a packet with a byte pending.
    for (int b = 0; b < 5; b++) push(0, 8'(8'hE0 + b), b == 4);
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);
    do_reset();
    chk("t6_grant", 32'(o_grant), 32'd0);
    chk("t6_ready", 32'(o_req_ready), 32'd0);
    chk("t6_tx_valid", 32'(o_user_tx_valid), 32'd0);
    chk("t6_tx_data", 32'(o_user_tx_data), 32'd0);
    chk("t6_busy", 32'(o_busy), 32'd0);
    push(3, 8'h3E, 1'b1);
    step(4'b1001, 1'b1);
    chk("t6_req0_wins", 32'(o_grant), 32'h1);

    // Randomized traffic with random stalls and occasional resets.
    for (int cyc = 0; cyc < 800; cyc++) begin
      logic [3:0] vm;
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        for (int k = 0; k < N; k++) begin
          if (src[k].size() < 3 && $urandom_range(0, 9) < 3) gen_packet(k);
          vm[k] = ($urandom_range(0, 9) < 7);
        end
        step(vm, $urandom_range(0, 3) != 0);
      end
    end

    // Drain everything still queued.
    left = 1;
    for (int c = 0; c < 3000 && left != 0; c++) begin
      step(4'b1111, 1'b1);
      left = src[0].size() + src[1].size() + src[2].size() + src[3].size() + int'(m_out_v);
    end
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    chk("drain_sources", 32'(src[0].size() + src[1].size() + src[2].size() + src[3].size()),
        32'd0);
    chk("drain_scoreboard", 32'(q_sent.size()), 32'd0);
    chk("drain_idle", 32'(o_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
